// File: rtl/main_memory_responder_if.sv
// Bus-side request/flush/response bundle between snooping caches and main memory.
// The master drives requests, flushes and rsp_ready; the slave is the memory responder.
interface main_memory_responder_if #(
   parameter int ADDRESSWIDTH = 16,
   parameter int DATABUSWIDTH = 32
);
   logic                    req_valid;
   logic                    req_write;
   logic [ADDRESSWIDTH-1:0] req_address;
   logic [DATABUSWIDTH-1:0] req_wdata;
   logic                    req_ready;
   logic                    flush_valid;
   logic [ADDRESSWIDTH-1:0] flush_address;
   logic [DATABUSWIDTH-1:0] flush_data;
   logic                    rsp_valid;
   logic                    rsp_write;
   logic [DATABUSWIDTH-1:0] rsp_rdata;
   logic                    rsp_ready;

   modport master (
      output req_valid, req_write, req_address, req_wdata,
      output flush_valid, flush_address, flush_data,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_address, req_wdata,
      input  flush_valid, flush_address, flush_data,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_rdata
   );
endinterface

// File: rtl/main_memory_responder.sv
// Main memory responder: one block read or write-back at a time with fixed latency,
// absorbing dirty-line flushes and forwarding a matching flush as the read response.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// BUSY    | latency countdown; matching flushes captured for reads
// RESPOND | response held until rsp_ready
module main_memory_responder #(
   parameter int ADDRESSWIDTH = 16,
   parameter int DATABUSWIDTH = 32,
   parameter int MEMLATENCY   = 4
) (
   input logic                   clock,
   input logic                   reset,
   main_memory_responder_if.slave bus
);
   localparam int BW = ADDRESSWIDTH - 2;

   typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

   state_t                  state;
   logic [3:0]              count;
   logic [BW-1:0]           blk_addr;
   logic                    write_q;
   logic [DATABUSWIDTH-1:0] wdata_q;
   logic [DATABUSWIDTH-1:0] flush_q;
   logic                    flush_hit;
   logic                    req_ready_q;
   logic                    rsp_valid_q;
   logic                    rsp_write_q;
   logic [DATABUSWIDTH-1:0] rsp_rdata_q;

   logic [DATABUSWIDTH-1:0] mem [2**BW];

   logic [BW-1:0] flush_blk;
   logic          flush_match;
   logic          commit;
   logic          unused_low_bits;

   assign flush_blk       = bus.flush_address[ADDRESSWIDTH-1:2];
   assign flush_match     = (state == BUSY) && !write_q && bus.flush_valid && (flush_blk == blk_addr);
   assign commit          = (state == BUSY) && (count == 4'd0);
   assign unused_low_bits = ^{bus.req_address[1:0], bus.flush_address[1:0]};

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   // Array is not reset; writes are blocked while reset is held. The write-back
   // commit is assigned last so it wins over a same-block flush in that cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         if (bus.flush_valid)
            mem[flush_blk] <= bus.flush_data;
         if (commit && write_q)
            mem[blk_addr] <= wdata_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= 4'd0;
         blk_addr    <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         flush_q     <= '0;
         flush_hit   <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  blk_addr    <= bus.req_address[ADDRESSWIDTH-1:2];
                  write_q     <= bus.req_write;
                  wdata_q     <= bus.req_wdata;
                  count       <= 4'(MEMLATENCY - 1);
                  flush_hit   <= 1'b0;
                  req_ready_q <= 1'b0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (flush_match) begin
                  flush_q   <= bus.flush_data;
                  flush_hit <= 1'b1;
               end
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  state       <= RESPOND;
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= write_q;
                  // A flush arriving on the final BUSY cycle is the freshest copy
                  if (write_q)
                     rsp_rdata_q <= wdata_q;
                  else if (flush_match)
                     rsp_rdata_q <= bus.flush_data;
                  else if (flush_hit)
                     rsp_rdata_q <= flush_q;
                  else
                     rsp_rdata_q <= mem[blk_addr];
               end
            end
            RESPOND: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Bus-side memory responder servicing block requests issued by the snooping caches over the common bus. It accepts one read-fill or dirty-victim write-back at a time, models a fixed memory latency, and returns a 32-bit block (4 bytes) or a write acknowledgement. During a read, a snooping cache holding the line modified can flush it; that data is captured into memory and forwarded as the response.

## Interface
- ADDRESSWIDTH, 16, bus byte address width; block address = address[ADDRESSWIDTH-1:2]
- DATABUSWIDTH, 32, block width (4 bytes, byte 0 in bits [7:0])
- MEMLATENCY, 4, cycles from request acceptance to response, legal range 1..15
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all control state
- req_valid  in  1  request present (BusRd fill or write-back)
- req_write  in  1  1 = write-back of victim block, 0 = block read
- req_address  in  ADDRESSWIDTH  byte address; bits [1:0] ignored
- req_wdata  in  DATABUSWIDTH  write-back block data
- req_ready  out  1  responder can accept a request
- flush_valid  in  1  snooping cache is flushing a modified block
- flush_address  in  ADDRESSWIDTH  address of flushed block
- flush_data  in  DATABUSWIDTH  flushed block data
- rsp_valid  out  1  response available
- rsp_write  out  1  response acknowledges a write-back
- rsp_rdata  out  DATABUSWIDTH  read block, or written data echoed for write-back
- rsp_ready  in  1  requester consumes the response

## Operation
- Storage: 2^(ADDRESSWIDTH-2) words × DATABUSWIDTH. Array contents are not reset; bench preloads via write-backs.
- States: IDLE, BUSY, RESPOND.
- IDLE: req_ready=1. On req_valid: latch block address, req_write, req_wdata; load counter = MEMLATENCY-1; clear flush_hit; go to BUSY.
- BUSY: req_ready=0.
  - Counter decrements each cycle while nonzero.
  - Read only: if flush_valid and flush_address[15:2] equals the latched block address, latch flush_data, set flush_hit, and write flush_data to the array that cycle. A later matching flush overwrites.
  - At counter==0, go to RESPOND:
    - Write: array[addr] ← latched wdata; rsp_rdata = wdata; rsp_write=1.
    - Read: rsp_rdata = flush_hit ? latched flush data : array[addr]; rsp_write=0.
- RESPOND: rsp_valid=1 and rsp_rdata is held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
- flush_valid in IDLE, in RESPOND, or during a write-back: written to the array directly (dirty-line flush to memory). If it coincides with a write-back commit to the same block, the write-back wins.
- rsp_valid and req_ready are never both 1.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, counter=0, flush_hit=0.
- Acceptance at edge E0. rsp_valid rises after edge E0+MEMLATENCY. With MEMLATENCY=1, BUSY lasts exactly one cycle.
- Response consumed at edge Ec, where rsp_valid&&rsp_ready. req_ready=1 after Ec; the next request is accepted no earlier than edge Ec+1. Minimum request spacing is MEMLATENCY+2 cycles.
- Write commit happens on the BUSY→RESPOND edge, so a read accepted after the ack returns the new data.
- Reset asserted mid-operation: immediate return to IDLE, rsp_valid=0, req_ready=1. A pending request is dropped; an uncommitted write-back is not performed. A flush is written only if it was sampled before reset asserted.
- rsp_ready held low: responder stalls in RESPOND indefinitely with stable outputs.

## Test plan
- Write-back 0xA1B2C3D4 to 0x1234, then read 0x1236 → write ack after 4 cycles (rsp_write=1); read rsp_rdata=0xA1B2C3D4 exactly 4 cycles after acceptance (bits [1:0] ignored).
- Read 0x0040 with flush_valid, flush_address=0x0040, flush_data=0xDEADBEEF at cycle 2 of BUSY → rsp_rdata=0xDEADBEEF. A subsequent plain read of 0x0040 → 0xDEADBEEF.
- Read 0x0040 with flush to 0x0080 during BUSY → rsp_rdata = array value of 0x0040. Read 0x0080 → flushed data.
- rsp_ready held low 10 cycles → rsp_valid and rsp_rdata stable, req_ready=0; second req_valid is not accepted until one cycle after the handshake.
- Reset pulsed low on cycle 2 of a write-back 0x55AA55AA to 0x0100 → outputs at reset values. A read of 0x0100 returns the old contents.
- MEMLATENCY=1 build: back-to-back requests → rsp_valid exactly one cycle after each acceptance; spacing is 3 cycles with rsp_ready=1.
